// File: rtl/led_pkg.sv
// Shared types and constants for the LED controller.
// Purely declarative: no timing or flow control.
// No flow control.
package led_pkg;
  localparam int                 LED_W               = 4;
  localparam logic [LED_W-1:0]   LED_RESET_PAT       = 4'b0001;
  localparam logic               KEY_PRESSED         = 1'b0;
  localparam int                 DEBOUNCE_CYCLES_DEF = 16;

  function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction
endpackage

// File: rtl/key_debounce.sv
// Key synchroniser, debouncer and press-edge detector; LED_DEBOUNCE_EN enables the stability counter.
// Latency: key_stable falls DEBOUNCE_CYCLES+1 edges after first low sample (2 edges without the counter).
// No backpressure: press is a single-cycle pulse that must be consumed when it appears.
module key_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_stable,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1, sync2;
  logic key_stable_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= ~KEY_PRESSED;
      sync2 <= ~KEY_PRESSED;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

`ifdef LED_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // Any sample matching the accepted level restarts the count, rejecting bounces.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_stable <= ~KEY_PRESSED;
      cnt        <= '0;
    end else if (sync2 == key_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      key_stable <= sync2;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  // Still registered so the undebounced build keeps a 3-edge key-to-LED latency.
  always_ff @(posedge clk) begin
    if (!rst) key_stable <= ~KEY_PRESSED;
    else      key_stable <= sync2;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) key_stable_q <= ~KEY_PRESSED;
    else      key_stable_q <= key_stable;
  end

  assign press = (key_stable_q != KEY_PRESSED) && (key_stable == KEY_PRESSED);

endmodule

// File: rtl/led_ctrl_top.sv
// Push-button LED rotator: each debounced press rotates a one-hot pattern across the LEDs.
// Latency: DEBOUNCE_CYCLES+2 edges key-to-LED (3 edges without LED_DEBOUNCE_EN); led is registered.
// No backpressure: every press event is applied in the cycle it occurs.
module led_ctrl_top
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_in,
  output logic [LED_W-1:0] led
);

  logic key_stable;
  logic press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_stable(key_stable),
    .press     (press)
  );

  always_ff @(posedge clk) begin
    if (!rst)       led <= LED_RESET_PAT;
    else if (press) led <= rotl(led);
  end

endmodule

// File: tb/tb_led_ctrl_top.sv
// Directed bench for led_ctrl_top; expectations adapt to whether LED_DEBOUNCE_EN is defined.
module tb_led_ctrl_top;
  localparam int DC = 16;
`ifdef LED_DEBOUNCE_EN
  localparam int LAT = DC + 2;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_in = 1'b1;
  logic [3:0] led;

  int total = 0;
  int bad = 0;
  int press_cnt = 0;
  int base;

  led_ctrl_top #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst   (rst),
    .key_in(key_in),
    .led   (led)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (dut.u_deb.press === 1'b1) press_cnt = press_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp4 [4];
    logic [3:0] exp_pre_rst;
    logic [3:0] exp_pulse;
    exp4[0] = 4'b0100; exp4[1] = 4'b1000; exp4[2] = 4'b0001; exp4[3] = 4'b0010;

    // Reset held for two edges, key released.
    tick();
    chk("reset_first_edge", {28'd0, led}, 32'h1);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("idle_after_reset", {28'd0, led}, 32'h1);

`ifdef LED_DEBOUNCE_EN
    // Bounce train shorter than the debounce window.
    base = press_cnt;
    key_in = 1'b0; #10;
    key_in = 1'b1; #40;
    key_in = 1'b0; #30;
    key_in = 1'b1; #10;
    key_in = 1'b0; #10;
    key_in = 1'b1; #100;
    tick();
    repeat (DC + 4) tick();
    chk("bounce_led", {28'd0, led}, 32'h1);
    chk("bounce_press", press_cnt - base, 32'd0);
`endif

    // Held press: exact latency, single event.
    base = press_cnt;
    key_in = 1'b0;
    repeat (LAT) tick();
    chk("press_not_early", {28'd0, led}, 32'h1);
    tick();
    chk("press_latency", {28'd0, led}, 32'h2);
    chk("press_one_event", press_cnt - base, 32'd1);
    repeat (30) tick();
    chk("held_no_change", {28'd0, led}, 32'h2);
    chk("held_press_count", press_cnt - base, 32'd1);
    key_in = 1'b1;
    repeat (LAT + 4) tick();
    chk("release_no_change", {28'd0, led}, 32'h2);
    chk("release_no_event", press_cnt - base, 32'd1);

    // Four full press/release cycles.
    for (int k = 0; k < 4; k++) begin
      base = press_cnt;
      key_in = 1'b0;
      repeat (40) tick();
      chk($sformatf("cycle%0d_press", k), {28'd0, led}, {28'd0, exp4[k]});
      key_in = 1'b1;
      repeat (40) tick();
      chk($sformatf("cycle%0d_release", k), {28'd0, led}, {28'd0, exp4[k]});
      chk($sformatf("cycle%0d_events", k), press_cnt - base, 32'd1);
    end

    // Reset in the middle of a held press, then a fresh debounce.
`ifdef LED_DEBOUNCE_EN
    exp_pre_rst = 4'b0010;
`else
    exp_pre_rst = 4'b0100;
`endif
    key_in = 1'b0;
    repeat (10) tick();
    chk("mid_press_pre_reset", {28'd0, led}, {28'd0, exp_pre_rst});
    rst = 1'b0;
    tick();
    chk("mid_press_reset", {28'd0, led}, 32'h1);
    rst = 1'b1;
    repeat (LAT) tick();
    chk("post_reset_not_early", {28'd0, led}, 32'h1);
    tick();
    chk("post_reset_fresh_press", {28'd0, led}, 32'h2);
    key_in = 1'b1;
    repeat (LAT + 6) tick();

    // Three-cycle low pulse: accepted only without the debounce counter.
`ifdef LED_DEBOUNCE_EN
    exp_pulse = 4'b0010;
`else
    exp_pulse = 4'b0100;
`endif
    key_in = 1'b0;
    repeat (3) tick();
    key_in = 1'b1;
    chk("pulse_not_early", {28'd0, led}, 32'h2);
    tick();
    chk("pulse_3_edges", {28'd0, led}, {28'd0, exp_pulse});
    repeat (DC + 6) tick();
    chk("pulse_settled", {28'd0, led}, {28'd0, exp_pulse});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
